// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-way registered mux and its arbiters.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Channel-index width: at least one bit even for a single channel.
  function automatic int sel_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/mux_n_way_reg_rr_pick.sv
// Rotating-priority picker: first asserted request at or after ptr, wrapping
// from N-1 back to 0. Purely combinational.
module rr_pick
  import mux_pkg::*;
#(
  parameter  int N    = 8,
  localparam int SELW = sel_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_vld
);

  int c;

  // Walk from the farthest candidate back toward ptr so the nearest hit wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    c       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      c       = (int'(ptr) + k >= N) ? (int'(ptr) + k - N) : (int'(ptr) + k);
      gnt_vld = gnt_vld | req[c];
      gnt_idx = req[c] ? SELW'(c) : gnt_idx;
    end
  end

endmodule

// File: rtl/mux_n_way_reg.sv
// N-way W-bit mux with fixed or round-robin selection and a registered
// valid/ready output stage. Define MUX_N_WAY_XFER_CNT_EN to add xfer_cnt.
module mux_n_way_reg
  import mux_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int W    = 16,
  localparam int SELW = sel_width(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_chan,
  output logic            out_valid,
  input  logic            out_ready
`ifdef MUX_N_WAY_XFER_CNT_EN
  ,
  output logic [15:0]     xfer_cnt
`endif
);

  logic [W-1:0]    out_data_q,  out_data_d;
  logic [SELW-1:0] out_chan_q,  out_chan_d;
  logic            out_valid_q, out_valid_d;
  logic [SELW-1:0] ptr_q,       ptr_d;

  logic            accept_s;
  logic            rr_vld_s,  fix_vld_s,  gnt_vld_s;
  logic [SELW-1:0] rr_idx_s,  fix_idx_s,  gnt_idx_s;
  logic [W-1:0]    gnt_data_s;

  rr_pick #(.N(N)) u_rr_pick (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_idx (rr_idx_s),
    .gnt_vld (rr_vld_s)
  );

  // Fixed select: an out-of-range sel matches no channel and so never grants.
  always_comb begin
    fix_vld_s = 1'b0;
    fix_idx_s = sel;
    for (int i = 0; i < N; i++) begin
      fix_vld_s = fix_vld_s | ((sel == SELW'(i)) && in_valid[i]);
    end
  end

  // Grant selection, selected data and the one-hot per-channel ready.
  always_comb begin
    accept_s = !out_valid_q || out_ready;
    case (mode)
      MODE_RR: begin
        gnt_vld_s = rr_vld_s;
        gnt_idx_s = rr_idx_s;
      end
      MODE_FIXED: begin
        gnt_vld_s = fix_vld_s;
        gnt_idx_s = fix_idx_s;
      end
      default: begin
        gnt_vld_s = 1'b0;
        gnt_idx_s = '0;
      end
    endcase
    gnt_data_s = '0;
    in_ready   = '0;
    for (int i = 0; i < N; i++) begin
      gnt_data_s  = (gnt_idx_s == SELW'(i)) ? in_data[i*W +: W] : gnt_data_s;
      in_ready[i] = accept_s && gnt_vld_s && (gnt_idx_s == SELW'(i));
    end
  end

  // Output stage and round-robin pointer next state.
  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (accept_s) begin
      if (gnt_vld_s) begin
        out_data_d  = gnt_data_s;
        out_chan_d  = gnt_idx_s;
        out_valid_d = 1'b1;
        if (mode == MODE_RR) begin
          ptr_d = (int'(gnt_idx_s) == N - 1) ? '0 : (gnt_idx_s + SELW'(1));
        end else begin
          ptr_d = ptr_q;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers; reset drops any held word immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

`ifdef MUX_N_WAY_XFER_CNT_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  // Count words leaving the output stage; wraps naturally at 16 bits.
  always_comb begin
    if (out_valid_q && out_ready) begin
      xfer_cnt_d = xfer_cnt_q + 16'd1;
    end else begin
      xfer_cnt_d = xfer_cnt_q;
    end
  end

  // Transfer counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xfer_cnt_q <= 16'd0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_mux_n_way_reg.sv
// Self-checking bench for mux_n_way_reg (N=8, W=16) against a behavioural model.
module tb_mux_n_way_reg;

  localparam int N    = 8;
  localparam int W    = 16;
  localparam int SELW = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            mode;
  logic [SELW-1:0] sel;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_chan;
  logic            out_valid;
  logic            out_ready;
`ifdef MUX_N_WAY_XFER_CNT_EN
  logic [15:0]     xfer_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Model state
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_chan;
  int           m_ptr;
  int           m_cnt;
  logic         e_gv;
  int           e_gi;
  logic [N-1:0] e_ready;

  mux_n_way_reg #(.N(N), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUX_N_WAY_XFER_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_chan  = 0;
    m_ptr   = 0;
    m_cnt   = 0;
  endtask

  // Expected grant and ready from the current inputs and model state.
  task automatic model_eval();
    logic acc;
    int   c;
    acc  = !m_valid || out_ready;
    e_gv = 1'b0;
    e_gi = 0;
    if (mode == 1'b0) begin
      if (int'(sel) < N && in_valid[sel]) begin
        e_gv = 1'b1;
        e_gi = int'(sel);
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (!e_gv && in_valid[c]) begin
          e_gv = 1'b1;
          e_gi = c;
        end
      end
    end
    e_ready = (acc && e_gv) ? (8'd1 << e_gi) : 8'd0;
  endtask

  // Clock edge: advance both DUT and model, then settle.
  task automatic tick();
    logic acc;
    model_eval();
    acc = !m_valid || out_ready;
    @(posedge clk);
    if (m_valid && out_ready) m_cnt = (m_cnt + 1) % 65536;
    if (acc) begin
      if (e_gv) begin
        m_valid = 1'b1;
        m_data  = in_data[e_gi*W +: W];
        m_chan  = e_gi;
        if (mode == 1'b1) m_ptr = (e_gi + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    mode = 1'b0; sel = 3'd0; in_data = '0; in_valid = 8'h00; out_ready = 1'b1;
    reset = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_chan !== 3'd0 || in_ready !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h chan=%0d ready=%b, required 0/0000/0/00000000",
               out_valid, out_data, out_chan, in_ready);
    end
    do_reset();
  endtask

  task automatic test_fixed_sweep();
    logic [W-1:0] tbl [N];
    tbl = '{16'h3141, 16'h5926, 16'h5358, 16'h9793, 16'h2384, 16'h6264, 16'h3383, 16'h2795};
    for (int i = 0; i < N; i++) in_data[i*W +: W] = tbl[i];
    in_valid = 8'hFF; out_ready = 1'b1; mode = 1'b0;
    for (int s = 0; s < N; s++) begin
      sel = SELW'(s);
      #1;
      model_eval();
      checks++;
      if (in_ready !== e_ready) begin
        errors++;
        $display("FAIL fixed_ready sel=%0d: got %b, required %b", s, in_ready, e_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== tbl[s] || int'(out_chan) != s) begin
        errors++;
        $display("FAIL fixed_out sel=%0d: got v=%b d=%h c=%0d, required v=1 d=%h c=%0d",
                 s, out_valid, out_data, out_chan, tbl[s], s);
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_seq [5];
    exp_seq = '{0, 2, 5, 7, 0};
    mode = 1'b1; in_valid = 8'b1010_0101; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (in_ready !== (8'd1 << exp_seq[i])) begin
        errors++;
        $display("FAIL rr_ready step=%0d: got %b, required one-hot ch%0d", i, in_ready, exp_seq[i]);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || int'(out_chan) != exp_seq[i] || out_data !== in_data[exp_seq[i]*W +: W]) begin
        errors++;
        $display("FAIL rr_chan step=%0d: got v=%b c=%0d, required v=1 c=%0d", i, out_valid, out_chan, exp_seq[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    logic [SELW-1:0] held_c;
    mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    tick();
    held = out_data; held_c = out_chan;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < N; c++) in_data[c*W +: W] = W'($urandom);
      #1;
      checks++;
      if (in_ready !== 8'h00 || out_valid !== 1'b1 || out_data !== held || out_chan !== held_c) begin
        errors++;
        $display("FAIL backpressure cyc=%0d: ready=%b v=%b d=%h c=%0d, required 0/1/%h/%0d",
                 i, in_ready, out_valid, out_data, out_chan, held, held_c);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    model_eval();
    checks++;
    if (in_ready !== e_ready || in_ready === 8'h00) begin
      errors++;
      $display("FAIL bp_release_ready: got %b, required %b", in_ready, e_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== m_data || int'(out_chan) != m_chan || int'(out_chan) != (int'(held_c) + 1) % N) begin
      errors++;
      $display("FAIL bp_release_word: got v=%b d=%h c=%0d, required v=1 d=%h c=%0d",
               out_valid, out_data, out_chan, m_data, m_chan);
    end
  endtask

  task automatic test_no_request();
    mode = 1'b0; sel = 3'd3; in_valid = 8'hF7; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 8'h00 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL noreq_ready: ready=%b v=%b, required 00000000 and pending word", in_ready, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== m_data || int'(out_chan) != m_chan) begin
      errors++;
      $display("FAIL noreq_drain: v=%b d=%h c=%0d, required v=0 d=%h c=%0d", out_valid, out_data, out_chan, m_data, m_chan);
    end
  endtask

  task automatic test_reset_mid();
    mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_chan !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid: v=%b d=%h c=%0d, required 0/0000/0", out_valid, out_data, out_chan);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (in_ready !== 8'h01) begin
      errors++;
      $display("FAIL reset_rr_restart: ready=%b, required 00000001", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_chan !== 3'd0) begin
      errors++;
      $display("FAIL reset_rr_first: v=%b c=%0d, required v=1 c=0", out_valid, out_chan);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      sel       = SELW'($urandom);
      in_valid  = N'($urandom);
      if ($urandom_range(0, 3) == 0) in_valid = 8'h00;
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < N; c++) in_data[c*W +: W] = W'($urandom);
      #1;
      model_eval();
      checks++;
      if (in_ready !== e_ready || out_valid !== m_valid || (m_valid && (out_data !== m_data || int'(out_chan) != m_chan))) begin
        errors++;
        $display("FAIL random cyc=%0d: ready=%b v=%b d=%h c=%0d, required ready=%b v=%b d=%h c=%0d",
                 i, in_ready, out_valid, out_data, out_chan, e_ready, m_valid, m_data, m_chan);
      end
      tick();
    end
  endtask

`ifdef MUX_N_WAY_XFER_CNT_EN
  task automatic test_xfer_cnt();
    do_reset();
    checks++;
    if (xfer_cnt !== 16'd0) begin
      errors++;
      $display("FAIL xfer_cnt_reset: got %0d, required 0", xfer_cnt);
    end
    mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 70001; i++) tick();
    checks++;
    if (xfer_cnt !== 16'd4464 || int'(xfer_cnt) != m_cnt) begin
      errors++;
      $display("FAIL xfer_cnt_wrap: got %0d, required 4464 (model %0d)", xfer_cnt, m_cnt);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_fixed_sweep();
    test_round_robin();
    test_backpressure();
    test_no_request();
    test_reset_mid();
    test_random();
`ifdef MUX_N_WAY_XFER_CNT_EN
    test_xfer_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
